// File: rtl/carrier_mixer_nco.sv
// Carrier NCO with 8-step cos/sin LUT mixer, TIC-latched wrap counter and phase.
// Registered outputs, 1-cycle latency from IF sample to mix product; no backpressure.
module carrier_mixer_nco #(
  parameter int ACC_W       = 30,
  parameter int CYC_W       = 20,
  parameter int PHASE_OUT_W = 10
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [ACC_W-1:0]       f_control,
  input  logic                   if_sign,
  input  logic                   if_mag,
  input  logic                   clear_phase,
  input  logic                   tic_enable,
  output logic                   mix_i_sign,
  output logic [2:0]             mix_i_mag,
  output logic                   mix_q_sign,
  output logic [2:0]             mix_q_mag,
  output logic [CYC_W-1:0]       carrier_cycles,
  output logic [PHASE_OUT_W-1:0] carrier_phase
);

  logic [ACC_W-1:0] phase;
  logic [ACC_W:0]   phase_sum;
  logic             carry;
  logic [2:0]       idx;
  logic [CYC_W-1:0] count;
  logic [CYC_W-1:0] count_inc;
  logic             cos_pos, cos_big;
  logic             sin_pos, sin_big;

  // |IF| is 1 or 3, |LUT| is 1 or 2, so the product lands in {1,2,3,6}.
  function automatic logic [2:0] prod_mag(input logic if_big, input logic lut_big);
    logic [2:0] m;
    case ({if_big, lut_big})
      2'b00:   m = 3'b001;
      2'b01:   m = 3'b010;
      2'b10:   m = 3'b011;
      default: m = 3'b110;
    endcase
    return m;
  endfunction

  always_comb begin
    phase_sum = {1'b0, phase} + {1'b0, f_control};
    carry     = phase_sum[ACC_W] & ~clear_phase;
    idx       = phase[ACC_W-1 -: 3];
    count_inc = (carry && (count != {CYC_W{1'b1}})) ? count + CYC_W'(1) : count;
  end

  // cos: +2,+1,-1,-2,-2,-1,+1,+2   sin: +1,+2,+2,+1,-1,-2,-2,-1
  always_comb begin
    cos_pos = 1'b0;
    cos_big = 1'b0;
    sin_pos = 1'b0;
    sin_big = 1'b0;
    case (idx)
      3'd0: begin cos_pos = 1'b1; cos_big = 1'b1; sin_pos = 1'b1; sin_big = 1'b0; end
      3'd1: begin cos_pos = 1'b1; cos_big = 1'b0; sin_pos = 1'b1; sin_big = 1'b1; end
      3'd2: begin cos_pos = 1'b0; cos_big = 1'b0; sin_pos = 1'b1; sin_big = 1'b1; end
      3'd3: begin cos_pos = 1'b0; cos_big = 1'b1; sin_pos = 1'b1; sin_big = 1'b0; end
      3'd4: begin cos_pos = 1'b0; cos_big = 1'b1; sin_pos = 1'b0; sin_big = 1'b0; end
      3'd5: begin cos_pos = 1'b0; cos_big = 1'b0; sin_pos = 1'b0; sin_big = 1'b1; end
      3'd6: begin cos_pos = 1'b1; cos_big = 1'b0; sin_pos = 1'b0; sin_big = 1'b1; end
      default: begin cos_pos = 1'b1; cos_big = 1'b1; sin_pos = 1'b0; sin_big = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase          <= '0;
      count          <= '0;
      carrier_cycles <= '0;
      carrier_phase  <= '0;
      mix_i_sign     <= 1'b0;
      mix_i_mag      <= 3'b000;
      mix_q_sign     <= 1'b0;
      mix_q_mag      <= 3'b000;
    end else begin
      phase      <= clear_phase ? '0 : phase_sum[ACC_W-1:0];
      // Mixing uses the pre-update (and pre-clear) phase of this edge.
      mix_i_sign <= ~(if_sign ^ cos_pos);
      mix_i_mag  <= prod_mag(if_mag, cos_big);
      mix_q_sign <= ~(if_sign ^ sin_pos);
      mix_q_mag  <= prod_mag(if_mag, sin_big);
      if (tic_enable) begin
        carrier_cycles <= count_inc;
        carrier_phase  <= clear_phase ? '0 : phase_sum[ACC_W-1 -: PHASE_OUT_W];
        count          <= '0;
      end else begin
        count <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_carrier_mixer_nco.sv
// Randomised and directed bench for carrier_mixer_nco against an arithmetic reference model.
module tb_carrier_mixer_nco;
  localparam int ACC_W = 12;
  localparam int PW    = 12;
  localparam int CYC_A = 20;
  localparam int CYC_B = 2;
  localparam int MAX_A = (1 << CYC_A) - 1;
  localparam int MAX_B = (1 << CYC_B) - 1;
  localparam int MODV  = 1 << ACC_W;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [ACC_W-1:0] f_control = '0;
  logic             if_sign = 1'b1;
  logic             if_mag = 1'b0;
  logic             clear_phase = 1'b0;
  logic             tic_enable = 1'b0;

  logic             a_i_sign, a_q_sign, b_i_sign, b_q_sign;
  logic [2:0]       a_i_mag, a_q_mag, b_i_mag, b_q_mag;
  logic [CYC_A-1:0] a_cycles;
  logic [CYC_B-1:0] b_cycles;
  logic [PW-1:0]    a_cphase, b_cphase;

  int checks = 0;
  int failures = 0;

  int m_phase, m_cnt_a, m_cnt_b, m_cyc_a, m_cyc_b, m_cph, e_i, e_q;
  int cos_t[8] = '{2, 1, -1, -2, -2, -1, 1, 2};
  int sin_t[8] = '{1, 2, 2, 1, -1, -2, -2, -1};

  carrier_mixer_nco #(.ACC_W(ACC_W), .CYC_W(CYC_A), .PHASE_OUT_W(PW)) dut_a (
    .clk(clk), .rstn(rstn), .f_control(f_control), .if_sign(if_sign), .if_mag(if_mag),
    .clear_phase(clear_phase), .tic_enable(tic_enable),
    .mix_i_sign(a_i_sign), .mix_i_mag(a_i_mag), .mix_q_sign(a_q_sign), .mix_q_mag(a_q_mag),
    .carrier_cycles(a_cycles), .carrier_phase(a_cphase));

  carrier_mixer_nco #(.ACC_W(ACC_W), .CYC_W(CYC_B), .PHASE_OUT_W(PW)) dut_b (
    .clk(clk), .rstn(rstn), .f_control(f_control), .if_sign(if_sign), .if_mag(if_mag),
    .clear_phase(clear_phase), .tic_enable(tic_enable),
    .mix_i_sign(b_i_sign), .mix_i_mag(b_i_mag), .mix_q_sign(b_q_sign), .mix_q_mag(b_q_mag),
    .carrier_cycles(b_cycles), .carrier_phase(b_cphase));

  always #5 clk = ~clk;

  function automatic logic exp_sign(input int v);
    return (v > 0);
  endfunction

  function automatic logic [2:0] exp_mag(input int v);
    return 3'(v < 0 ? -v : v);
  endfunction

  // Advance one clock edge, update the model from the inputs present at that edge.
  task automatic tick();
    int sum, idx, ifv, ca, cb;
    @(posedge clk);
    if (!rstn) begin
      m_phase = 0; m_cnt_a = 0; m_cnt_b = 0; m_cyc_a = 0; m_cyc_b = 0; m_cph = 0;
      e_i = 0; e_q = 0;
    end else begin
      idx = m_phase / (MODV / 8);
      ifv = (if_mag ? 3 : 1) * (if_sign ? 1 : -1);
      e_i = ifv * cos_t[idx];
      e_q = ifv * sin_t[idx];
      sum = m_phase + int'(f_control);
      ca = m_cnt_a + ((sum >= MODV && !clear_phase) ? 1 : 0);
      cb = m_cnt_b + ((sum >= MODV && !clear_phase) ? 1 : 0);
      if (ca > MAX_A) ca = MAX_A;
      if (cb > MAX_B) cb = MAX_B;
      m_phase = clear_phase ? 0 : sum % MODV;
      if (tic_enable) begin
        m_cyc_a = ca; m_cyc_b = cb; m_cph = m_phase / (1 << (ACC_W - PW));
        m_cnt_a = 0; m_cnt_b = 0;
      end else begin
        m_cnt_a = ca; m_cnt_b = cb;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; clear_phase = 1'b0; tic_enable = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    if_sign = 1'b1; if_mag = 1'b0; f_control = '0;
    do_reset();
    checks++;
    if ({a_i_sign, a_i_mag, a_q_sign, a_q_mag} !== 8'h00) begin
      failures++; $display("FAIL reset_mix got=%b%b%b%b exp=0", a_i_sign, a_i_mag, a_q_sign, a_q_mag);
    end
    checks++;
    if (a_cycles !== '0 || a_cphase !== '0 || b_cycles !== '0 || b_cphase !== '0) begin
      failures++; $display("FAIL reset_latch got=%0d/%0h/%0d/%0h exp=0", a_cycles, a_cphase, b_cycles, b_cphase);
    end
    tick();
    checks++;
    if ({a_i_sign, a_i_mag} !== 4'b1010) begin
      failures++; $display("FAIL reset_first_i got=%b/%b exp=1/010", a_i_sign, a_i_mag);
    end
    checks++;
    if ({a_q_sign, a_q_mag} !== 4'b1001) begin
      failures++; $display("FAIL reset_first_q got=%b/%b exp=1/001", a_q_sign, a_q_mag);
    end
  endtask

  task automatic test_rotation(input logic s, input logic m);
    if_sign = s; if_mag = m; f_control = 12'h200;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (a_i_sign !== exp_sign(e_i) || a_i_mag !== exp_mag(e_i)) begin
        failures++; $display("FAIL rotation_i k=%0d got=%b/%b exp=%b/%b", k, a_i_sign, a_i_mag, exp_sign(e_i), exp_mag(e_i));
      end
      checks++;
      if (a_q_sign !== exp_sign(e_q) || a_q_mag !== exp_mag(e_q)) begin
        failures++; $display("FAIL rotation_q k=%0d got=%b/%b exp=%b/%b", k, a_q_sign, a_q_mag, exp_sign(e_q), exp_mag(e_q));
      end
      if (m) begin
        checks++;
        if (a_i_mag !== 3'b110 && a_i_mag !== 3'b011) begin
          failures++; $display("FAIL rotation_mag3 k=%0d got=%b exp=110|011", k, a_i_mag);
        end
      end
    end
  endtask

  task automatic test_tic();
    if_sign = 1'b1; if_mag = 1'b0; f_control = 12'h200;
    do_reset();
    repeat (19) tick();
    tic_enable = 1'b1; tick(); tic_enable = 1'b0;
    checks++;
    if (a_cycles !== CYC_A'(m_cyc_a) || a_cphase !== PW'(m_cph)) begin
      failures++; $display("FAIL tic_first got=%0d/%0h exp=%0d/%0h", a_cycles, a_cphase, m_cyc_a, m_cph);
    end
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (a_cycles !== CYC_A'(m_cyc_a) || a_cphase !== PW'(m_cph)) begin
        failures++; $display("FAIL tic_hold k=%0d got=%0d/%0h exp=%0d/%0h", k, a_cycles, a_cphase, m_cyc_a, m_cph);
      end
    end
    tic_enable = 1'b1; tick(); tic_enable = 1'b0;
    checks++;
    if (a_cycles !== CYC_A'(1) || a_cphase !== PW'(m_cph)) begin
      failures++; $display("FAIL tic_second got=%0d/%0h exp=1/%0h", a_cycles, a_cphase, m_cph);
    end
  endtask

  task automatic test_clear_tic();
    if_sign = 1'b1; if_mag = 1'b0; f_control = 12'h200;
    do_reset();
    repeat (4) tick();
    clear_phase = 1'b1; tic_enable = 1'b1; tick(); clear_phase = 1'b0; tic_enable = 1'b0;
    checks++;
    if (a_cycles !== CYC_A'(m_cyc_a) || a_cphase !== '0) begin
      failures++; $display("FAIL clear_tic_latch got=%0d/%0h exp=%0d/0", a_cycles, a_cphase, m_cyc_a);
    end
    checks++;
    if (a_i_sign !== exp_sign(e_i) || a_i_mag !== exp_mag(e_i)) begin
      failures++; $display("FAIL clear_tic_preidx got=%b/%b exp=%b/%b", a_i_sign, a_i_mag, exp_sign(e_i), exp_mag(e_i));
    end
    tick();
    checks++;
    if ({a_i_sign, a_i_mag, a_q_sign, a_q_mag} !== 8'b1010_1001) begin
      failures++; $display("FAIL clear_tic_idx0 got=%b%b%b%b exp=10101001", a_i_sign, a_i_mag, a_q_sign, a_q_mag);
    end
  endtask

  task automatic test_saturation();
    f_control = 12'h800;
    do_reset();
    repeat (11) tick();
    tic_enable = 1'b1; tick(); tic_enable = 1'b0;
    checks++;
    if (b_cycles !== 2'd3) begin
      failures++; $display("FAIL sat_narrow got=%0d exp=3", b_cycles);
    end
    checks++;
    if (a_cycles !== CYC_A'(m_cyc_a)) begin
      failures++; $display("FAIL sat_wide got=%0d exp=%0d", a_cycles, m_cyc_a);
    end
    repeat (3) tick();
    tic_enable = 1'b1; tick(); tic_enable = 1'b0;
    checks++;
    if (b_cycles !== CYC_B'(m_cyc_b)) begin
      failures++; $display("FAIL sat_restart got=%0d exp=%0d", b_cycles, m_cyc_b);
    end
  endtask

  task automatic test_freeze();
    logic [7:0] held;
    if_sign = 1'b0; if_mag = 1'b1; f_control = 12'h123;
    do_reset();
    repeat (5) tick();
    f_control = '0;
    tick();
    held = {a_i_sign, a_i_mag, a_q_sign, a_q_mag};
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({a_i_sign, a_i_mag, a_q_sign, a_q_mag} !== held || a_i_mag !== exp_mag(e_i)) begin
        failures++; $display("FAIL freeze k=%0d got=%b%b%b%b exp=%b", k, a_i_sign, a_i_mag, a_q_sign, a_q_mag, held);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      f_control   = ($urandom_range(0, 9) == 0) ? '0 : ACC_W'($urandom);
      if_sign     = 1'($urandom);
      if_mag      = 1'($urandom);
      clear_phase = ($urandom_range(0, 15) == 0);
      tic_enable  = ($urandom_range(0, 7) == 0);
      rstn        = ($urandom_range(0, 299) != 0);
      tick();
      checks++;
      if (a_i_sign !== exp_sign(e_i) || a_i_mag !== exp_mag(e_i) ||
          a_q_sign !== exp_sign(e_q) || a_q_mag !== exp_mag(e_q) ||
          b_i_sign !== exp_sign(e_i) || b_q_mag !== exp_mag(e_q)) begin
        failures++; $display("FAIL random_mix k=%0d got=%b%b%b%b exp_i=%0d exp_q=%0d", k, a_i_sign, a_i_mag, a_q_sign, a_q_mag, e_i, e_q);
      end
      checks++;
      if (a_cycles !== CYC_A'(m_cyc_a) || a_cphase !== PW'(m_cph) ||
          b_cycles !== CYC_B'(m_cyc_b) || b_cphase !== PW'(m_cph)) begin
        failures++; $display("FAIL random_latch k=%0d got=%0d/%0h/%0d exp=%0d/%0h/%0d", k, a_cycles, a_cphase, b_cycles, m_cyc_a, m_cph, m_cyc_b);
      end
    end
    rstn = 1'b1; clear_phase = 1'b0; tic_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation(1'b1, 1'b0);
    test_rotation(1'b0, 1'b1);
    test_tic();
    test_clear_tic();
    test_saturation();
    test_freeze();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
